// File: rtl/gtxe2_chnl_tx_oob_pkg.sv
// Shared definitions for the GTXE2 transmit OOB generator.
//   - oob_state_e : sequencer states (IDLE / BURST / GAP)
//   - DEF_*       : default SATA OOB timing in UI (one serial clock each)
//   - max2        : helper used to size the UI counter
package gtxe2_chnl_tx_oob_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } oob_state_e;

  localparam int unsigned DEF_BURST_COUNT   = 6;
  localparam int unsigned DEF_BURST_LEN     = 160;
  localparam int unsigned DEF_INIT_IDLE_LEN = 480;
  localparam int unsigned DEF_WAKE_IDLE_LEN = 160;
  localparam int unsigned DEF_SAS_IDLE_LEN  = 1440;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_tx_oob_burstgen.sv
// Burst pattern generator for the OOB sequencer.
// Produces the alternating 1/0 burst pattern and flags the last UI of a burst.
//   clk, rst_n : serial clock, synchronous active-low reset
//   en_i       : sequencer is in BURST
//   start_i    : sequencer enters BURST on this edge (pattern restarts at 1)
//   ucnt_i     : current UI count within the burst
//   ptn_o      : burst pattern bit (TXP value during a burst)
//   eob_o      : last UI of the burst
module gtxe2_chnl_tx_oob_burstgen
  import gtxe2_chnl_tx_oob_pkg::*;
#(
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned UW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          start_i,
  input  logic [UW-1:0] ucnt_i,
  output logic          ptn_o,
  output logic          eob_o
);

  logic ptn_q, ptn_d;

  // Loaded with 1 on the entry edge so the first burst UI is already high.
  always_comb begin
    ptn_d = ptn_q;
    if (start_i)   ptn_d = 1'b1;
    else if (en_i) ptn_d = ~ptn_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptn_q <= 1'b0;
    else        ptn_q <= ptn_d;
  end

  assign ptn_o = ptn_q;
  assign eob_o = en_i && (ucnt_i == UW'(BURST_LEN - 1));

endmodule

// File: rtl/gtxe2_chnl_tx_oob.sv
// GTXE2 channel transmit-side OOB signalling generator (COMINIT/COMWAKE,
// optionally COMSAS). One clk cycle is one UI. On a request it emits
// BURST_COUNT bursts of alternating data, each followed by an electrical-idle
// gap, then pulses TXCOMFINISH. Outside a sequence it passes serial data
// through or drives electrical idle.
// Optional feature macro: GTXE2_CHNL_TX_OOB_SAS_EN (adds TXCOMSAS input).
//   clk, rst_n  : serial clock, synchronous active-low reset
//   txser_in    : serializer output
//   TXELECIDLE  : drive idle when no sequence is running
//   TXCOMINIT   : COMINIT/COMRESET request (level, highest priority)
//   TXCOMWAKE   : COMWAKE request (level)
//   TXCOMSAS    : COMSAS request (level, lowest priority, macro only)
//   TXCOMFINISH : one-cycle pulse when a sequence completes
//   busy        : sequence in progress
//   TXP, TXN    : serial pins
module gtxe2_chnl_tx_oob
  import gtxe2_chnl_tx_oob_pkg::*;
#(
  parameter int unsigned BURST_COUNT   = DEF_BURST_COUNT,
  parameter int unsigned BURST_LEN     = DEF_BURST_LEN,
  parameter int unsigned INIT_IDLE_LEN = DEF_INIT_IDLE_LEN,
  parameter int unsigned WAKE_IDLE_LEN = DEF_WAKE_IDLE_LEN,
  parameter int unsigned SAS_IDLE_LEN  = DEF_SAS_IDLE_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic txser_in,
  input  logic TXELECIDLE,
  input  logic TXCOMINIT,
  input  logic TXCOMWAKE,
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
  input  logic TXCOMSAS,
`endif
  output logic TXCOMFINISH,
  output logic busy,
  output logic TXP,
  output logic TXN
);

  // Sized for every length the parameter set can name (SAS included), so the
  // counter width does not change when the SAS option is switched on.
  localparam int unsigned MAXLEN = max2(max2(BURST_LEN, INIT_IDLE_LEN),
                                        max2(WAKE_IDLE_LEN, SAS_IDLE_LEN));
  localparam int unsigned UW     = $clog2(MAXLEN + 1);

  oob_state_e    state_q, state_d;
  logic [UW-1:0] ucnt_q, ucnt_d;
  logic [UW-1:0] gap_q, gap_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic          fin_q, fin_d;
  logic          busy_q, busy_d;
  logic          go;
  logic          start;
  logic          ptn, eob;

  always_comb begin
    state_d = state_q;
    ucnt_d  = ucnt_q;
    gap_d   = gap_q;
    bcnt_d  = bcnt_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    go      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TXCOMINIT) begin
          gap_d = UW'(INIT_IDLE_LEN);
          go    = 1'b1;
        end else if (TXCOMWAKE) begin
          gap_d = UW'(WAKE_IDLE_LEN);
          go    = 1'b1;
        end
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
        else if (TXCOMSAS) begin
          gap_d = UW'(SAS_IDLE_LEN);
          go    = 1'b1;
        end
`endif
        if (go) begin
          state_d = BURST;
          ucnt_d  = '0;
          bcnt_d  = '0;
          busy_d  = 1'b1;
        end
      end
      BURST: begin
        if (eob) begin
          state_d = GAP;
          ucnt_d  = '0;
        end else begin
          ucnt_d = ucnt_q + UW'(1);
        end
      end
      GAP: begin
        if (ucnt_q == gap_q - UW'(1)) begin
          ucnt_d = '0;
          if (bcnt_q == 4'(BURST_COUNT - 1)) begin
            state_d = IDLE;
            bcnt_d  = '0;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
          end else begin
            state_d = BURST;
            bcnt_d  = bcnt_q + 4'd1;
          end
        end else begin
          ucnt_d = ucnt_q + UW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ucnt_d  = '0;
        bcnt_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ucnt_q  <= '0;
      gap_q   <= '0;
      bcnt_q  <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ucnt_q  <= ucnt_d;
      gap_q   <= gap_d;
      bcnt_q  <= bcnt_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
    end
  end

  // Pattern restarts on every entry into BURST (from IDLE or from a gap).
  assign start = (state_d == BURST) && (state_q != BURST);

  gtxe2_chnl_tx_oob_burstgen #(
    .BURST_LEN (BURST_LEN),
    .UW        (UW)
  ) u_burstgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (state_q == BURST),
    .start_i (start),
    .ucnt_i  (ucnt_q),
    .ptn_o   (ptn),
    .eob_o   (eob)
  );

  // Pins are forced low combinationally while reset is held, so an abort
  // silences the line in the same cycle reset is asserted.
  always_comb begin
    TXP = 1'b0;
    TXN = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (!TXELECIDLE) begin
            TXP = txser_in;
            TXN = ~txser_in;
          end
        end
        BURST: begin
          TXP = ptn;
          TXN = ~ptn;
        end
        default: ;
      endcase
    end
  end

  assign TXCOMFINISH = fin_q;
  assign busy        = busy_q;

endmodule
